// File: rtl/trivium_xor_cipher.sv
// -----------------------------------------------------------------------------
// trivium_xor_cipher
//   Consumes the serial keystream of a trivium generator and applies it to a
//   word stream. The block holds the generator enable high during warm-up. After
//   warm-up it issues exactly WIDTH enables per word and packs the returned bits
//   LSB-first into a keystream word. It then XORs that word with one accepted
//   input word and presents the result as a registered output.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-low reset
//   ks_bit     in   1      generator keystream bit (lags its enable by one edge)
//   ks_valid   in   1      generator warm-up complete
//   ks_enable  out  1      one generator step per high cycle
//   in_data    in   WIDTH  input word
//   in_valid   in   1      input word valid
//   in_ready   out  1      input word accepted this cycle when in_valid is high
//   out_data   out  WIDTH  in_data ^ keystream word (registered)
//   out_valid  out  1      out_data valid
//   out_ready  in   1      sink accepts out_data
// -----------------------------------------------------------------------------
module trivium_xor_cipher #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ks_bit,
  input  logic             ks_valid,
  output logic             ks_enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LP_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0] LP_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_issue_cnt;
  logic [CW-1:0]    r_samp_cnt;
  logic             r_en_q;
  logic [WIDTH-1:0] r_ks_word;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             w_ks_enable;
  logic             w_in_ready;
  logic             w_sample;
  logic             w_accept;

  // Next-state decode plus raw enable/ready/sample strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ks_enable = 1'b0;
    w_in_ready  = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_WARM: begin
        w_ks_enable = 1'b1;
        if (ks_valid) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_WARM;
        end
      end
      ST_FILL: begin
        w_ks_enable = (r_issue_cnt < LP_WIDTH);
        // A bit is meaningful one edge after a FILL-issued enable
        w_sample    = r_en_q && ks_valid;
        if (!ks_valid) begin
          w_state_nxt = ST_WARM;
        end else if (w_sample && (r_samp_cnt == LP_LAST)) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_ARMED: begin
        // A generator drop discards the armed word, so no handshake then
        w_in_ready = ks_valid && (!r_out_valid || out_ready);
        if (!ks_valid) begin
          w_state_nxt = ST_WARM;
        end else if (w_in_ready && in_valid) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      default: begin
        w_state_nxt = ST_WARM;
      end
    endcase
  end

  // Enable and ready are held low while reset is asserted
  assign ks_enable = rst && w_ks_enable;
  assign in_ready  = rst && w_in_ready;
  assign w_accept  = in_ready && in_valid;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // State, counters, keystream packing and output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_WARM;
      r_issue_cnt <= {CW{1'b0}};
      r_samp_cnt  <= {CW{1'b0}};
      r_en_q      <= 1'b0;
      r_ks_word   <= {WIDTH{1'b0}};
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Only enables issued in FILL are tracked, so the bit stepped out by
      // the last warm-up enable is never taken as keystream
      r_en_q  <= (r_state == ST_FILL) && w_ks_enable;
      // Counters run only while staying in FILL; any entry into FILL starts at 0
      if ((r_state == ST_FILL) && (w_state_nxt == ST_FILL)) begin
        r_issue_cnt <= r_issue_cnt + {{(CW-1){1'b0}}, w_ks_enable};
        r_samp_cnt  <= r_samp_cnt + {{(CW-1){1'b0}}, w_sample};
      end else begin
        r_issue_cnt <= {CW{1'b0}};
        r_samp_cnt  <= {CW{1'b0}};
      end
      // Right shift: after WIDTH samples the first bit sits in bit 0
      if (w_sample) begin
        r_ks_word <= {ks_bit, r_ks_word[WIDTH-1:1]};
      end else begin
        r_ks_word <= r_ks_word;
      end
      // A same-cycle accept and drain replaces the word and keeps valid high
      if (w_accept) begin
        r_out_data  <= in_data ^ r_ks_word;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

endmodule
